// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP subtract issue controller.
package fpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } issue_state_t;

  typedef enum logic {
    FOP_SUB = 1'b0,
    FOP_ADD = 1'b1
  } fop_t;

  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam int          FP_SIGN_BIT = 31;

  // x1 + x2 is issued to the subtractor as x1 - (-x2).
  function automatic logic [31:0] fp_adjust_x2(input logic [31:0] x2, input fop_t op);
    fp_adjust_x2 = x2;
    if (op == FOP_ADD) fp_adjust_x2[FP_SIGN_BIT] = ~x2[FP_SIGN_BIT];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above ptr, wrapping around.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fsub_issue_ctrl.sv
// Shares one multi-cycle FP subtract unit among N_REQ requesters, one op at a time.
//
// state | meaning
// IDLE  | arbitrate; accept when a request is pending and the unit reports idle
// ISSUE | one-cycle unit_en strobe with registered operands
// BUSY  | wait for the unit to drop idle (accepted)
// WAIT  | wait for idle back high with valid; capture result
// RESP  | present result to owner until it is taken
module fsub_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_op,
  input  logic [N_REQ*32-1:0]  req_x1,
  input  logic [N_REQ*32-1:0]  req_x2,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [31:0]          resp_y,
  output logic                 unit_en,
  output logic [31:0]          unit_x1,
  output logic [31:0]          unit_x2,
  input  logic [31:0]          unit_y,
  input  logic                 unit_valid,
  input  logic                 unit_idle,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int IW = $clog2(N_REQ);

  issue_state_t  state, state_nxt;
  logic [IW-1:0] ptr, owner, grant_idx;
  logic [N_REQ-1:0] grant;
  logic [7:0]    tmo_cnt;
  logic          accept, done, tmo;
  logic [31:0]   sel_x1, sel_x2;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_x1 = req_x1[int'(grant_idx)*32 +: 32];
  assign sel_x2 = fp_adjust_x2(req_x2[int'(grant_idx)*32 +: 32], fop_t'(req_op[grant_idx]));
  assign accept = |req_ready;

  // A stale unit_valid from the previous op is ignored: only idle returning high in WAIT completes.
  assign done = (state == WAIT) && unit_idle && unit_valid;
  assign tmo  = ((state == BUSY) || (state == WAIT)) && !done && (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = BUSY;
      BUSY: begin
        if (tmo)             state_nxt = RESP;
        else if (!unit_idle) state_nxt = WAIT;
      end
      WAIT:    if (done || tmo) state_nxt = RESP;
      RESP:    if (resp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An X on unit_idle falls through the if and blocks the accept.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    unit_en    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (|req_valid && unit_idle) req_ready = grant;
      ISSUE:   unit_en = 1'b1;
      RESP:    resp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr         <= IW'(N_REQ - 1);
      owner       <= '0;
      unit_x1     <= '0;
      unit_x2     <= '0;
      resp_y      <= '0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      if (accept) begin
        unit_x1 <= sel_x1;
        unit_x2 <= sel_x2;
        owner   <= grant_idx;
        ptr     <= grant_idx;
      end
      if (state == ISSUE)
        tmo_cnt <= '0;
      else if ((state == BUSY) || (state == WAIT))
        tmo_cnt <= tmo_cnt + 8'd1;
      if (done) begin
        resp_y <= unit_y;
      end else if (tmo) begin
        resp_y      <= FP_QNAN;
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsub_issue_ctrl.sv
// Self-checking bench for fsub_issue_ctrl with a behavioural stub of the FP unit.
module tb_fsub_issue_ctrl;
  import fpu_ctrl_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 15;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_op, resp_valid, resp_ready;
  logic [N*32-1:0] req_x1, req_x2;
  logic [31:0]     resp_y, unit_x1, unit_x2, unit_y;
  logic            unit_en, unit_valid, unit_idle, busy, err_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsub_issue_ctrl #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_x1      (req_x1),
    .req_x2      (req_x2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_y      (resp_y),
    .unit_en     (unit_en),
    .unit_x1     (unit_x1),
    .unit_x2     (unit_x2),
    .unit_y      (unit_y),
    .unit_valid  (unit_valid),
    .unit_idle   (unit_idle),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // Unit stub: known FP pairs give exact results, anything else a fixed scramble.
  function automatic logic [31:0] unit_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h40000000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
  endfunction

  int          u_lat = 2, u_start = 0, u_phase = 0, u_wait = 0, u_cnt = 0;
  bit          u_hang_hi = 0, u_hang_lo = 0, u_kill = 0;
  logic [31:0] u_res;

  always @(posedge clk) begin
    if (u_kill) begin
      u_phase = 0;
      unit_idle <= 1'b1;
    end else begin
      case (u_phase)
        0: if (unit_en === 1'b1) begin
          u_res  = unit_ref(unit_x1, unit_x2);
          u_cnt  = u_lat - 1;
          u_wait = u_start;
          if (u_hang_hi)      u_phase = 3;
          else if (u_start > 0) u_phase = 1;
          else begin u_phase = 2; unit_idle <= 1'b0; end
        end
        1: begin
          u_wait--;
          if (u_wait == 0) begin u_phase = 2; unit_idle <= 1'b0; end
        end
        2: if (!u_hang_lo) begin
          if (u_cnt == 0) begin
            unit_idle <= 1'b1; unit_valid <= 1'b1; unit_y <= u_res; u_phase = 0;
          end else u_cnt--;
        end
        default: ;
      endcase
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, resp_valid, unit_en, busy, err_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {req_ready, resp_valid, unit_en, busy, err_timeout});
    end
    checks++;
    if ({unit_x1, unit_x2, resp_y} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {unit_x1, unit_x2, resp_y});
    end
    @(negedge clk); rstn = 1'b1;
    // Unit idle is still X: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      nxt(); req_valid = 2'b01; smp();
      checks++;
      if (req_ready !== 2'b00 || unit_en !== 1'b0) begin
        failures++;
        $display("FAIL x_idle_accept req_ready=%b unit_en=%b exp=00/0", req_ready, unit_en);
      end
    end
    nxt(); u_kill = 1; req_valid = 2'b00; smp();
    nxt(); u_kill = 0; smp();
  endtask

  task automatic test_single_sub();
    nxt();
    req_valid = 2'b01; req_op = 2'b00;
    req_x1[31:0] = 32'h40400000; req_x2[31:0] = 32'h3F800000; resp_ready = 2'b00;
    smp();
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL sub_accept got=%b exp=01", req_ready); end
    nxt(); req_valid = 2'b00; smp();
    checks++;
    if (unit_en !== 1'b1 || unit_x1 !== 32'h40400000 || unit_x2 !== 32'h3F800000) begin
      failures++;
      $display("FAIL sub_issue en=%b x1=%h x2=%h exp=1/40400000/3f800000", unit_en, unit_x1, unit_x2);
    end
    for (int k = 2; k <= 4; k++) begin
      nxt(); smp();
      checks++;
      if (unit_en !== 1'b0 || resp_valid !== 2'b00) begin
        failures++;
        $display("FAIL sub_gap_T%0d en=%b resp_valid=%b exp=0/00", k, unit_en, resp_valid);
      end
    end
    nxt(); resp_ready = 2'b01; smp();
    checks++;
    if (resp_valid !== 2'b01 || resp_y !== 32'h40000000) begin
      failures++;
      $display("FAIL sub_resp_T5 valid=%b y=%h exp=01/40000000", resp_valid, resp_y);
    end
    nxt(); resp_ready = 2'b00; smp();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL sub_done busy=%b exp=0", busy); end
  endtask

  task automatic test_add();
    bit got = 0;
    nxt();
    req_valid = 2'b10; req_op = 2'b10;
    req_x1[63:32] = 32'h3F800000; req_x2[63:32] = 32'h3F800000;
    smp();
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL add_accept got=%b exp=10", req_ready); end
    nxt(); req_valid = 2'b00; smp();
    checks++;
    if (unit_en !== 1'b1 || unit_x2 !== 32'hBF800000) begin
      failures++;
      $display("FAIL add_x2 en=%b x2=%h exp=1/bf800000", unit_en, unit_x2);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      nxt(); resp_ready = 2'b10; smp();
      if (resp_valid !== 2'b00) got = 1;
    end
    checks++;
    if (resp_valid !== 2'b10 || resp_y !== 32'h40000000) begin
      failures++;
      $display("FAIL add_resp valid=%b y=%h exp=10/40000000", resp_valid, resp_y);
    end
    nxt(); resp_ready = 2'b00; req_op = 2'b00; smp();
  endtask

  task automatic test_round_robin();
    int order[$];
    int when[$];
    int exp_order[6] = '{0, 1, 0, 1, 0, 0};
    nxt();
    req_valid = 2'b11; req_op = 2'b00; resp_ready = 2'b11;
    req_x1 = {32'h11111111, 32'h22222222}; req_x2 = {32'h33333333, 32'h44444444};
    smp();
    for (int c = 0; c < 200 && order.size() < 6; c++) begin
      if (req_ready !== 2'b00) begin
        order.push_back(req_ready == 2'b10 ? 1 : 0);
        when.push_back(c);
      end
      if (order.size() < 6) begin
        nxt(); if (order.size() >= 4) req_valid = 2'b01; smp();
      end
    end
    checks++;
    if (order.size() != 6) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=6", order.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          failures++;
          $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
        end
      end
      checks++;
      if (when[5] - when[4] != 6) begin
        failures++;
        $display("FAIL rr_spacing got=%0d exp=6", when[5] - when[4]);
      end
    end
    nxt(); req_valid = 2'b00; smp();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin nxt(); smp(); end
    nxt(); resp_ready = 2'b00; smp();
  endtask

  task automatic test_backpressure();
    logic [31:0] y_exp;
    bit got = 0;
    nxt();
    req_valid = 2'b01; req_op = 2'b01;
    req_x1[31:0] = 32'h12345678; req_x2[31:0] = 32'h0BADF00D;
    y_exp = unit_ref(32'h12345678, 32'h8BADF00D);
    smp();
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", req_ready); end
    nxt(); req_valid = 2'b10; req_op = 2'b00; smp();
    for (int i = 0; i < 20 && !got; i++) begin
      nxt(); smp();
      if (resp_valid !== 2'b00) got = 1;
    end
    for (int k = 0; k < 10; k++) begin
      nxt(); resp_ready = 2'b10; smp();
      checks++;
      if (resp_valid !== 2'b01 || resp_y !== y_exp || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%b y=%h ready=%b exp=01/%h/00", k, resp_valid, resp_y, req_ready, y_exp);
      end
    end
    nxt(); resp_ready = 2'b01; smp();
    nxt(); resp_ready = 2'b00; smp();
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    nxt(); req_valid = 2'b00; resp_ready = 2'b11; smp();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin nxt(); smp(); end
    nxt(); resp_ready = 2'b00; smp();
  endtask

  task automatic test_stale_valid();
    bit low_seen = 0, early = 0;
    int rise = -1, first = -1;
    u_start = 3;
    nxt(); req_valid = 2'b01; req_op = 2'b00; smp();
    nxt(); req_valid = 2'b00; smp();
    for (int c = 0; c < 40 && first < 0; c++) begin
      nxt(); resp_ready = 2'b01; smp();
      if (unit_idle === 1'b0) low_seen = 1;
      else if (low_seen && rise < 0) rise = c;
      if (resp_valid !== 2'b00) begin
        if (rise < 0) early = 1;
        first = c;
      end
    end
    checks++;
    if (early || first < 0 || first != rise + 1) begin
      failures++;
      $display("FAIL stale_valid resp_at=%0d idle_rise_at=%0d early=%0d exp resp_at=rise+1", first, rise, early);
    end
    nxt(); resp_ready = 2'b00; u_start = 0; smp();
  endtask

  task automatic test_timeout_reset();
    int hit = -1;
    bit got = 0;
    u_hang_hi = 1;
    nxt(); req_valid = 2'b01; req_op = 2'b00; smp();
    nxt(); req_valid = 2'b00; smp();
    for (int c = 1; c <= 40 && hit < 0; c++) begin
      nxt(); smp();
      if (err_timeout === 1'b1) hit = c;
    end
    checks++;
    if (hit < TMO || hit > TMO + 2) begin
      failures++;
      $display("FAIL tmo_cycle got=%0d exp=%0d..%0d", hit, TMO, TMO + 2);
    end
    checks++;
    if (resp_y !== FP_QNAN || resp_valid !== 2'b01) begin
      failures++;
      $display("FAIL tmo_resp y=%h valid=%b exp=%h/01", resp_y, resp_valid, FP_QNAN);
    end
    nxt(); resp_ready = 2'b01; smp();
    nxt(); resp_ready = 2'b00; u_kill = 1; u_hang_hi = 0; smp();
    nxt(); u_kill = 0; smp();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_sticky err=%b busy=%b exp=1/0", err_timeout, busy);
    end
    // Unit swallows the next op and never reports idle again: reset while in WAIT.
    u_hang_lo = 1;
    nxt(); req_valid = 2'b01; req_x1[31:0] = 32'hCAFEF00D; smp();
    nxt(); req_valid = 2'b00; smp();
    for (int i = 0; i < 4; i++) begin nxt(); smp(); end
    nxt(); rstn = 1'b0; #1;
    checks++;
    if ({req_ready, resp_valid, unit_en, busy, err_timeout} !== '0 || {unit_x1, unit_x2, resp_y} !== '0) begin
      failures++;
      $display("FAIL rst_async ctrl=%b data=%h exp=0", {req_ready, resp_valid, unit_en, busy, err_timeout},
               {unit_x1, unit_x2, resp_y});
    end
    @(negedge clk); rstn = 1'b1; req_valid = 2'b11; req_op = 2'b00;
    req_x1 = {32'hA5A5A5A5, 32'h5A5A5A5A}; req_x2 = {32'h01234567, 32'h89ABCDEF};
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      checks++;
      if (req_ready !== 2'b00 || unit_en !== 1'b0) begin
        failures++;
        $display("FAIL rst_wait_idle[%0d] ready=%b en=%b exp=00/0", i, req_ready, unit_en);
      end
    end
    nxt(); u_kill = 1; u_hang_lo = 0; smp();
    nxt(); u_kill = 0; smp();
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
    nxt(); req_valid = 2'b00; resp_ready = 2'b11; smp();
    for (int i = 0; i < 20 && !got; i++) begin
      nxt(); smp();
      if (resp_valid !== 2'b00) got = 1;
    end
    checks++;
    if (resp_valid !== 2'b01 || resp_y !== unit_ref(32'h5A5A5A5A, 32'h89ABCDEF)) begin
      failures++;
      $display("FAIL rst_after_op valid=%b y=%h exp=01/%h", resp_valid, resp_y, unit_ref(32'h5A5A5A5A, 32'h89ABCDEF));
    end
    nxt(); resp_ready = 2'b00; smp();
  endtask

  task automatic test_random();
    bit          m_free = 1;
    int          m_owner = 0, m_last = N - 1, m_cycles = 0, ops = 0, g;
    logic [31:0] m_x1, m_x2, m_y;
    logic [N-1:0] exp_ready;
    nxt(); rstn = 1'b0; req_valid = 2'b00; resp_ready = 2'b00; smp();
    nxt(); rstn = 1'b1; smp();
    for (int c = 0; c < 1500; c++) begin
      nxt();
      req_valid  = 2'($urandom_range(0, 3));
      req_op     = 2'($urandom_range(0, 3));
      req_x1     = {$urandom, $urandom};
      req_x2     = {$urandom, $urandom};
      resp_ready = 2'($urandom_range(0, 3));
      u_lat      = $urandom_range(1, 3);
      u_start    = $urandom_range(0, 2);
      smp();
      if (m_free) begin
        exp_ready = '0;
        g = -1;
        if (req_valid != 0 && unit_idle === 1'b1) begin
          g = rr_pick(req_valid, m_last);
          exp_ready[g] = 1'b1;
        end
        checks++;
        if (req_ready !== exp_ready) begin
          failures++;
          $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_ready);
        end
        if (g >= 0) begin
          m_free = 0; m_owner = g; m_last = g; m_cycles = 0;
          m_x1 = req_x1[g*32 +: 32];
          m_x2 = req_op[g] ? (req_x2[g*32 +: 32] ^ 32'h80000000) : req_x2[g*32 +: 32];
          m_y  = unit_ref(m_x1, m_x2);
        end
      end else begin
        m_cycles++;
        checks++;
        if (req_ready !== 2'b00) begin
          failures++;
          $display("FAIL rnd_ready_busy cyc=%0d got=%b exp=00", c, req_ready);
        end
        if (unit_en === 1'b1) begin
          checks++;
          if (unit_x1 !== m_x1 || unit_x2 !== m_x2) begin
            failures++;
            $display("FAIL rnd_operands cyc=%0d x1=%h x2=%h exp=%h/%h", c, unit_x1, unit_x2, m_x1, m_x2);
          end
        end
        if (resp_valid !== 2'b00) begin
          checks++;
          if (resp_valid !== (2'b01 << m_owner) || resp_y !== m_y) begin
            failures++;
            $display("FAIL rnd_resp cyc=%0d valid=%b y=%h exp=%b/%h", c, resp_valid, resp_y,
                     2'b01 << m_owner, m_y);
          end
          if (resp_ready[m_owner]) begin m_free = 1; ops++; end
        end
        if (!m_free && m_cycles > 60) begin
          checks++; failures++;
          $display("FAIL rnd_hang cyc=%0d waited=%0d limit=60", c, m_cycles);
          m_free = 1;
        end
      end
    end
    checks++;
    if (ops < 50) begin failures++; $display("FAIL rnd_ops got=%0d exp>=50", ops); end
    nxt(); req_valid = 2'b00; resp_ready = 2'b11; smp();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin nxt(); smp(); end
  endtask

  initial begin
    req_valid = '0; req_op = '0; req_x1 = '0; req_x2 = '0; resp_ready = '0;
    test_reset();
    test_single_sub();
    test_add();
    test_round_robin();
    test_backpressure();
    test_stale_valid();
    test_timeout_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsub_issue_ctrl.md
Name: fsub_issue_ctrl

Overview:
- Shares one multi-cycle FP subtract unit (en/idle/valid handshake, 32-bit x1/x2/y) between N_REQ requesters, e.g. the integer pipe and the FP load/convert helper.
- Arbitrates round-robin and issues one operation at a time.
- Turns add requests into subtracts by flipping the sign of x2.
- Returns each result to its owner through a valid/ready response port, and detects a hung unit with a timeout.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TIMEOUT, 15, max cycles from issue to unit completion before abort (4..255).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
- req_op  in  N_REQ  per requester: 0 = x1-x2, 1 = x1+x2
- req_x1  in  N_REQ*32  operand 1, requester i in bits [32i+31:32i]
- req_x2  in  N_REQ*32  operand 2, same packing
- resp_valid  out  N_REQ  result available for the owner (one-hot or zero)
- resp_ready  in  N_REQ  owner consumes the result
- resp_y  out  32  result, shared by all requesters
- unit_en  out  1  issue strobe to the unit
- unit_x1  out  32  unit operand 1
- unit_x2  out  32  unit operand 2, sign already adjusted
- unit_y  in  32  unit result
- unit_valid  in  1  unit result-valid level
- unit_idle  in  1  unit idle level
- busy  out  1  controller not in IDLE
- err_timeout  out  1  sticky: a timeout has occurred

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - req_ready, resp_valid, unit_en, busy, err_timeout = 0.
  - unit_x1, unit_x2, resp_y = 0.
  - State = IDLE, timeout counter = 0.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
- The unit itself has no reset.
  - An operation in flight when rstn asserts finishes inside the unit and its result is dropped.
  - The controller issues nothing until it samples unit_idle==1 in IDLE; an X on unit_idle counts as not idle.
- FSM states: IDLE, ISSUE, BUSY, WAIT, RESP.
- IDLE:
  - Arbiter grant = first requester with req_valid=1, searching upward from pointer+1 with wrap-around.
  - If any request is pending and unit_idle==1: req_ready[grant]=1 (combinational, same cycle).
  - On that cycle: latch x1; latch x2 with bit31 inverted when req_op=1; latch the owner; set pointer = grant; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - unit_en=1 for exactly this one cycle; unit_x1/unit_x2 hold the latched operands (registered, stable from this cycle until the next accept).
  - Timeout counter cleared to 0; go to BUSY.
- BUSY: wait for unit_idle==0, i.e. the unit has accepted.
- WAIT:
  - Wait for unit_idle==1 && unit_valid==1.
  - On that cycle capture resp_y = unit_y and go to RESP.
  - The unit's valid can stay high from the previous operation, so completion is qualified only by the idle 1->0->1 sequence; unit_valid alone is never sufficient.
- Timeout:
  - Counter increments every cycle in BUSY and WAIT.
  - If it reaches TIMEOUT: err_timeout=1 (sticky until reset), resp_y = 32'h7FC00000 (qNaN), go to RESP.
- RESP:
  - resp_valid[owner]=1, resp_y held stable.
  - Leave for IDLE on the cycle resp_ready[owner]==1.
  - resp_ready on any other index is ignored.
  - No new request is accepted in the RESP cycle.
- Latency: accept at cycle T -> unit_en at T+1 -> resp_valid first high at T+5, given a 3-stage unit.
- Throughput: at best one operation per 6 cycles, since a response taken at T+5 returns to IDLE at T+6.
- busy = (state != IDLE).
- A requester that drops req_valid before it is accepted is simply not granted; the pointer does not move.
- Simultaneous events:
  - A request pending while in RESP waits for IDLE.
  - Every pending requester other than the previous winner gets priority over it.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); a pending response is lost.

Decomposition:
- Package fpu_ctrl_pkg:
  - issue_state_t enum (IDLE, ISSUE, BUSY, WAIT, RESP)
  - fop_t enum (FOP_SUB=0, FOP_ADD=1)
  - FP_QNAN = 32'h7FC00000
  - FP_SIGN_BIT = 31
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N] and ptr.
  - Outputs a one-hot grant and a grant index.
  - Purely combinational; the pointer register stays in fsub_issue_ctrl.

Test Plan:
- Single sub: req0 op=0, x1=0x40400000, x2=0x3F800000, accepted at T -> unit_en only at T+1, resp_valid[0] at T+5, resp_y=0x40000000 (3.0-1.0).
- Add via sign flip: req1 op=1, x1=x2=0x3F800000 -> unit_x2=0xBF800000, resp_y=0x40000000 on resp_valid[1].
- Round-robin: req0 and req1 both held high for 4 operations -> grant order 0,1,0,1; after req1 drops, req0 is granted back-to-back.
- Backpressure: resp_ready[0] held 0 for 10 cycles -> resp_valid[0] and resp_y stay stable; req_ready stays 0 even with req1 pending; grant to req1 only after the response handshake.
- Stale valid: unit_valid held 1 throughout -> resp_valid does not assert until unit_idle has gone 0 then 1.
- Timeout and reset: unit model never lowers idle -> after TIMEOUT cycles err_timeout=1, resp_y=0x7FC00000. Assert rstn=0 while in WAIT -> outputs clear at once; after release, no issue until unit_idle==1.
